vram_arbiter: RTL and testbench

- Shares the single-port synchronous character/pixel VRAM between three requesters:
  - the character display engine (fixed-latency reads, absolute priority);
  - a host register/CPU port (reads and writes through a valid/ready handshake);
  - an internal fill sequencer that clears or fills all of VRAM.
- Sits between the display engine's vram_addr/vram_data pins and the SRAM macro.

---
 rtl/vram_arb_pkg.sv | 23 ++
 rtl/vram_fill_seq.sv | 85 ++++++++
 rtl/vram_arbiter.sv | 188 ++++++++++++++++++
 tb/tb_vram_arbiter.sv | 420 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vram_arb_pkg.sv
// vram_arb_pkg: shared types and default sizing for the VRAM arbiter slice.
//   grant_t      - owner of the SRAM slot in the current cycle
//   fill_state_t - fill sequencer states
//   VRAM_AW_DEF / VRAM_DW_DEF - default address / data widths
package vram_arb_pkg;

  localparam int unsigned VRAM_AW_DEF = 11;
  localparam int unsigned VRAM_DW_DEF = 8;

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_DISP,
    GNT_HOST,
    GNT_FILL
  } grant_t;

  typedef enum logic [1:0] {
    FILL_IDLE,
    FILL_RUN,
    FILL_DONE
  } fill_state_t;

endpackage

// File: rtl/vram_fill_seq.sv
// vram_fill_seq: walks every VRAM address once, writing a latched fill value.
// Ports:
//   clk, rst_n        - clock, asynchronous active-low reset
//   fill_start        - pulse; accepted only in FILL_IDLE, latches fill_value
//   fill_value [DW]   - fill data
//   grant             - the arbiter gave this cycle's slot to the sequencer
//   want              - sequencer requests the slot (RUN state)
//   addr [AW], data [DW] - write address / data for the granted slot
//   busy              - fill in progress
//   done              - one-cycle pulse after the final write
module vram_fill_seq
  import vram_arb_pkg::*;
#(
  parameter int unsigned AW = VRAM_AW_DEF,
  parameter int unsigned DW = VRAM_DW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          fill_start,
  input  logic [DW-1:0] fill_value,
  input  logic          grant,
  output logic          want,
  output logic [AW-1:0] addr,
  output logic [DW-1:0] data,
  output logic          busy,
  output logic          done
);

  fill_state_t   state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] value_q, value_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FILL_IDLE;
      addr_q  <= '0;
      value_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      value_q <= value_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    value_d = value_q;
    case (state_q)
      FILL_IDLE: begin
        if (fill_start) begin
          state_d = FILL_RUN;
          addr_d  = '0;
          value_d = fill_value;
        end
      end
      FILL_RUN: begin
        if (grant) begin
          addr_d = addr_q + AW'(1);
          if (addr_q == '1) state_d = FILL_DONE;
        end
      end
      FILL_DONE: state_d = FILL_IDLE;
      default:   state_d = FILL_IDLE;
    endcase
  end

  always_comb begin
    want = 1'b0;
    busy = 1'b0;
    done = 1'b0;
    case (state_q)
      FILL_RUN: begin
        want = 1'b1;
        busy = 1'b1;
      end
      FILL_DONE: done = 1'b1;
      default: ;
    endcase
  end

  assign addr = addr_q;
  assign data = value_q;

endmodule

// File: rtl/vram_arbiter.sv
// vram_arbiter: shares one single-port synchronous VRAM between the display
// engine (absolute priority, never stalled), a one-entry buffered host port
// and the fill sequencer (round-robin between host and fill).
// Ports:
//   clk, rst_n                    - clock, asynchronous active-low reset
//   disp_req/disp_addr/disp_data  - display fetch; data returns next cycle
//   host_valid/host_ready/host_we/host_addr/host_wdata - host request
//   host_rvalid/host_rdata        - host read response
//   fill_start/fill_value/fill_busy/fill_done - whole-VRAM fill control
//   host_stall_cnt                - cycles a host request waited
//   sram_addr/sram_we/sram_wdata/sram_rdata - SRAM macro pins
// Build option: define VRAM_ARB_STATS_EN to enable host_stall_cnt;
// otherwise it reads as zero.
module vram_arbiter
  import vram_arb_pkg::*;
#(
  parameter int unsigned AW = VRAM_AW_DEF,
  parameter int unsigned DW = VRAM_DW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          disp_req,
  input  logic [AW-1:0] disp_addr,
  output logic [DW-1:0] disp_data,
  input  logic          host_valid,
  output logic          host_ready,
  input  logic          host_we,
  input  logic [AW-1:0] host_addr,
  input  logic [DW-1:0] host_wdata,
  output logic          host_rvalid,
  output logic [DW-1:0] host_rdata,
  input  logic          fill_start,
  input  logic [DW-1:0] fill_value,
  output logic          fill_busy,
  output logic          fill_done,
  output logic [15:0]   host_stall_cnt,
  output logic [AW-1:0] sram_addr,
  output logic          sram_we,
  output logic [DW-1:0] sram_wdata,
  input  logic [DW-1:0] sram_rdata
);

  grant_t        grant;
  logic          host_issue;
  logic          host_accept;
  logic          fill_want;
  logic          fill_grant;
  logic [AW-1:0] fill_addr;
  logic [DW-1:0] fill_data;

  logic          pending_q, pending_d;
  logic          buf_we_q, buf_we_d;
  logic [AW-1:0] buf_addr_q, buf_addr_d;
  logic [DW-1:0] buf_wdata_q, buf_wdata_d;
  logic          last_host_q, last_host_d;
  logic          rvalid_q, rvalid_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic [AW-1:0] addr_hold_q, addr_hold_d;
  logic [DW-1:0] wdata_hold_q, wdata_hold_d;

  vram_fill_seq #(
    .AW(AW),
    .DW(DW)
  ) u_fill (
    .clk        (clk),
    .rst_n      (rst_n),
    .fill_start (fill_start),
    .fill_value (fill_value),
    .grant      (fill_grant),
    .want       (fill_want),
    .addr       (fill_addr),
    .data       (fill_data),
    .busy       (fill_busy),
    .done       (fill_done)
  );

  // last_host_q resets to 0 ("fill granted last") so host wins the first tie.
  always_comb begin
    grant = GNT_NONE;
    if (disp_req)                    grant = GNT_DISP;
    else if (pending_q && fill_want) grant = last_host_q ? GNT_FILL : GNT_HOST;
    else if (pending_q)              grant = GNT_HOST;
    else if (fill_want)              grant = GNT_FILL;
  end

  assign host_issue  = (grant == GNT_HOST);
  assign fill_grant  = (grant == GNT_FILL);
  assign host_ready  = !pending_q || host_issue;
  assign host_accept = host_valid && host_ready;

  // Idle slots keep the previous address/data on the SRAM pins.
  always_comb begin
    sram_addr  = addr_hold_q;
    sram_wdata = wdata_hold_q;
    sram_we    = 1'b0;
    case (grant)
      GNT_DISP: sram_addr = disp_addr;
      GNT_HOST: begin
        sram_addr  = buf_addr_q;
        sram_wdata = buf_wdata_q;
        sram_we    = buf_we_q;
      end
      GNT_FILL: begin
        sram_addr  = fill_addr;
        sram_wdata = fill_data;
        sram_we    = 1'b1;
      end
      default: ;
    endcase
    addr_hold_d  = sram_addr;
    wdata_hold_d = sram_wdata;
  end

  always_comb begin
    pending_d   = pending_q;
    buf_we_d    = buf_we_q;
    buf_addr_d  = buf_addr_q;
    buf_wdata_d = buf_wdata_q;
    if (host_accept) begin
      pending_d   = 1'b1;
      buf_we_d    = host_we;
      buf_addr_d  = host_addr;
      buf_wdata_d = host_wdata;
    end else if (host_issue) begin
      pending_d = 1'b0;
    end
  end

  always_comb begin
    last_host_d = last_host_q;
    if (grant == GNT_HOST)      last_host_d = 1'b1;
    else if (grant == GNT_FILL) last_host_d = 1'b0;
  end

  // Read data arrives from the SRAM in the rvalid cycle; it is forwarded
  // straight through then and held in rdata_q afterwards.
  always_comb begin
    rvalid_d = host_issue && !buf_we_q;
    rdata_d  = rvalid_q ? sram_rdata : rdata_q;
  end

  assign host_rvalid = rvalid_q;
  assign host_rdata  = rvalid_q ? sram_rdata : rdata_q;
  assign disp_data   = sram_rdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q    <= 1'b0;
      buf_we_q     <= 1'b0;
      buf_addr_q   <= '0;
      buf_wdata_q  <= '0;
      last_host_q  <= 1'b0;
      rvalid_q     <= 1'b0;
      rdata_q      <= '0;
      addr_hold_q  <= '0;
      wdata_hold_q <= '0;
    end else begin
      pending_q    <= pending_d;
      buf_we_q     <= buf_we_d;
      buf_addr_q   <= buf_addr_d;
      buf_wdata_q  <= buf_wdata_d;
      last_host_q  <= last_host_d;
      rvalid_q     <= rvalid_d;
      rdata_q      <= rdata_d;
      addr_hold_q  <= addr_hold_d;
      wdata_hold_q <= wdata_hold_d;
    end
  end

`ifdef VRAM_ARB_STATS_EN
  logic [15:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (pending_q && !host_issue && (stall_q != '1)) stall_d = stall_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stall_q <= '0;
    else        stall_q <= stall_d;
  end

  assign host_stall_cnt = stall_q;
`else
  assign host_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter: bench for vram_arbiter (AW=4, DW=8) with a behavioural
// SRAM, a transaction-level reference model and directed/random scenarios.
module tb_vram_arbiter;

  localparam int unsigned AW    = 4;
  localparam int unsigned DW    = 8;
  localparam int          DEPTH = 16;

  logic          clk;
  logic          rst_n;
  logic          disp_req;
  logic [AW-1:0] disp_addr;
  logic [DW-1:0] disp_data;
  logic          host_valid;
  logic          host_ready;
  logic          host_we;
  logic [AW-1:0] host_addr;
  logic [DW-1:0] host_wdata;
  logic          host_rvalid;
  logic [DW-1:0] host_rdata;
  logic          fill_start;
  logic [DW-1:0] fill_value;
  logic          fill_busy;
  logic          fill_done;
  logic [15:0]   host_stall_cnt;
  logic [AW-1:0] sram_addr;
  logic          sram_we;
  logic [DW-1:0] sram_wdata;
  logic [DW-1:0] sram_rdata;

  int n_checks;
  int n_fail;
  bit mon_en;

  vram_arbiter #(
    .AW(AW),
    .DW(DW)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .disp_req       (disp_req),
    .disp_addr      (disp_addr),
    .disp_data      (disp_data),
    .host_valid     (host_valid),
    .host_ready     (host_ready),
    .host_we        (host_we),
    .host_addr      (host_addr),
    .host_wdata     (host_wdata),
    .host_rvalid    (host_rvalid),
    .host_rdata     (host_rdata),
    .fill_start     (fill_start),
    .fill_value     (fill_value),
    .fill_busy      (fill_busy),
    .fill_done      (fill_done),
    .host_stall_cnt (host_stall_cnt),
    .sram_addr      (sram_addr),
    .sram_we        (sram_we),
    .sram_wdata     (sram_wdata),
    .sram_rdata     (sram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural single-port SRAM, one-cycle registered read.
  logic [DW-1:0] sram_mem [DEPTH];
  always @(posedge clk) begin
    if (sram_we) sram_mem[sram_addr] <= sram_wdata;
    sram_rdata <= sram_mem[sram_addr];
  end

  // Reference model: who owns each slot, plus expected VRAM contents.
  bit m_pending, m_req_we, m_last_host, m_fill_on, m_fill_done, m_rv, m_disp_prev;
  int m_req_addr, m_req_data, m_fill_idx, m_fill_val;
  int m_rdata_now, m_rdata_hold, m_last_addr, m_stall, m_disp_exp;
  int m_mem [DEPTH];

  always @(negedge clk) begin : scoreboard
    int who, e_addr, e_we, e_wd, e_rd, e_st;
    bit e_ready, n_rv, n_done, start_ok;
    #2;
    if (!rst_n) begin
      m_pending = 0; m_req_we = 0; m_last_host = 0; m_fill_on = 0;
      m_fill_done = 0; m_rv = 0; m_disp_prev = 0; m_rdata_hold = 0;
      m_last_addr = 0; m_stall = 0; m_fill_idx = 0;
    end else if (mon_en) begin
      if (disp_req)                     who = 1;
      else if (m_pending && m_fill_on)  who = m_last_host ? 3 : 2;
      else if (m_pending)               who = 2;
      else if (m_fill_on)               who = 3;
      else                              who = 0;
      e_wd = 0;
      case (who)
        1: begin e_addr = int'(disp_addr); e_we = 0; end
        2: begin e_addr = m_req_addr; e_we = int'(m_req_we); e_wd = m_req_data; end
        3: begin e_addr = m_fill_idx; e_we = 1; e_wd = m_fill_val; end
        default: begin e_addr = m_last_addr; e_we = 0; end
      endcase
      e_ready = !m_pending || (who == 2);
      e_rd = m_rv ? m_rdata_now : m_rdata_hold;
`ifdef VRAM_ARB_STATS_EN
      e_st = m_stall;
`else
      e_st = 0;
`endif
      n_checks++;
      if (sram_we !== e_we[0]) begin n_fail++; $display("FAIL sb_sram_we: got %b want %0d (t=%0t)", sram_we, e_we, $time); end
      n_checks++;
      if (sram_addr !== AW'(e_addr)) begin n_fail++; $display("FAIL sb_sram_addr: got %0h want %0h (t=%0t)", sram_addr, e_addr, $time); end
      if (e_we == 1) begin
        n_checks++;
        if (sram_wdata !== DW'(e_wd)) begin n_fail++; $display("FAIL sb_sram_wdata: got %0h want %0h (t=%0t)", sram_wdata, e_wd, $time); end
      end
      n_checks++;
      if (host_ready !== e_ready) begin n_fail++; $display("FAIL sb_host_ready: got %b want %b (t=%0t)", host_ready, e_ready, $time); end
      n_checks++;
      if (host_rvalid !== m_rv) begin n_fail++; $display("FAIL sb_host_rvalid: got %b want %b (t=%0t)", host_rvalid, m_rv, $time); end
      n_checks++;
      if (host_rdata !== DW'(e_rd)) begin n_fail++; $display("FAIL sb_host_rdata: got %0h want %0h (t=%0t)", host_rdata, e_rd, $time); end
      n_checks++;
      if (fill_busy !== m_fill_on) begin n_fail++; $display("FAIL sb_fill_busy: got %b want %b (t=%0t)", fill_busy, m_fill_on, $time); end
      n_checks++;
      if (fill_done !== m_fill_done) begin n_fail++; $display("FAIL sb_fill_done: got %b want %b (t=%0t)", fill_done, m_fill_done, $time); end
      n_checks++;
      if (host_stall_cnt !== 16'(e_st)) begin n_fail++; $display("FAIL sb_stall_cnt: got %0d want %0d (t=%0t)", host_stall_cnt, e_st, $time); end
      if (m_disp_prev) begin
        n_checks++;
        if (disp_data !== DW'(m_disp_exp)) begin n_fail++; $display("FAIL sb_disp_data: got %0h want %0h (t=%0t)", disp_data, m_disp_exp, $time); end
      end

      // Advance the model across the coming clock edge.
      start_ok    = fill_start && !m_fill_on && !m_fill_done;
      m_disp_prev = (who == 1);
      if (who == 1) m_disp_exp = m_mem[disp_addr];
      if (who != 0) m_last_addr = e_addr;
      if (m_pending && who != 2 && m_stall < 65535) m_stall++;
      if (m_rv) m_rdata_hold = m_rdata_now;
      n_rv = 0;
      n_done = 0;
      if (who == 2) begin
        if (m_req_we) m_mem[m_req_addr] = m_req_data;
        else begin n_rv = 1; m_rdata_now = m_mem[m_req_addr]; end
        m_last_host = 1;
      end
      if (who == 3) begin
        m_mem[m_fill_idx] = m_fill_val;
        m_last_host = 0;
        if (m_fill_idx == DEPTH - 1) begin m_fill_on = 0; n_done = 1; end
        else m_fill_idx++;
      end
      if (host_valid && e_ready) begin
        m_pending = 1; m_req_we = host_we;
        m_req_addr = int'(host_addr); m_req_data = int'(host_wdata);
      end else if (who == 2) begin
        m_pending = 0;
      end
      if (start_ok) begin m_fill_on = 1; m_fill_idx = 0; m_fill_val = int'(fill_value); end
      m_fill_done = n_done;
      m_rv = n_rv;
    end
  end

  task automatic drive_idle();
    disp_req   = 1'b0;
    host_valid = 1'b0;
    host_we    = 1'b0;
    fill_start = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    drive_idle();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive_idle();
    disp_addr = '0; host_addr = '0; host_wdata = '0; fill_value = '0;
    @(negedge clk);
    @(negedge clk);
    #3;
    n_checks++; if (host_ready !== 1'b1) begin n_fail++; $display("FAIL reset_host_ready: got %b want 1", host_ready); end
    n_checks++; if (host_rvalid !== 1'b0) begin n_fail++; $display("FAIL reset_host_rvalid: got %b want 0", host_rvalid); end
    n_checks++; if (host_rdata !== '0) begin n_fail++; $display("FAIL reset_host_rdata: got %0h want 0", host_rdata); end
    n_checks++; if (fill_busy !== 1'b0) begin n_fail++; $display("FAIL reset_fill_busy: got %b want 0", fill_busy); end
    n_checks++; if (fill_done !== 1'b0) begin n_fail++; $display("FAIL reset_fill_done: got %b want 0", fill_done); end
    n_checks++; if (host_stall_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_stall_cnt: got %0d want 0", host_stall_cnt); end
    n_checks++; if (sram_we !== 1'b0) begin n_fail++; $display("FAIL reset_sram_we: got %b want 0", sram_we); end
    n_checks++; if (sram_addr !== '0) begin n_fail++; $display("FAIL reset_sram_addr: got %0h want 0", sram_addr); end
    @(negedge clk);
    rst_n  = 1'b1;
    mon_en = 1'b1;
  endtask

  task automatic test_write_read();
    @(negedge clk);
    host_valid = 1'b1; host_we = 1'b1; host_addr = 4'h5; host_wdata = 8'h41;
    #3;
    n_checks++; if (host_ready !== 1'b1) begin n_fail++; $display("FAIL wr_accept: host_ready got %b want 1", host_ready); end
    @(negedge clk);
    host_we = 1'b0;
    #3;
    n_checks++; if (host_ready !== 1'b1) begin n_fail++; $display("FAIL rd_accept_b2b: host_ready got %b want 1", host_ready); end
    @(negedge clk);
    host_valid = 1'b0;
    #3;
    n_checks++; if (host_rvalid !== 1'b0) begin n_fail++; $display("FAIL rd_early_rvalid: got %b want 0", host_rvalid); end
    @(negedge clk);
    #3;
    n_checks++; if (host_rvalid !== 1'b1) begin n_fail++; $display("FAIL rd_rvalid: got %b want 1", host_rvalid); end
    n_checks++; if (host_rdata !== 8'h41) begin n_fail++; $display("FAIL rd_rdata: got %0h want 41", host_rdata); end
    @(negedge clk);
    #3;
    n_checks++; if (host_rvalid !== 1'b0) begin n_fail++; $display("FAIL rd_rvalid_pulse: got %b want 0", host_rvalid); end
  endtask

  task automatic test_disp_stall();
    logic [AW-1:0] da;
    int exp_st;
    apply_reset();
    @(negedge clk);
    host_valid = 1'b1; host_we = 1'b0; host_addr = 4'h5;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      host_valid = 1'b0;
      da = AW'($urandom_range(0, DEPTH - 1));
      disp_req = 1'b1; disp_addr = da;
      #3;
      n_checks++; if (sram_addr !== da) begin n_fail++; $display("FAIL stall_disp_addr: got %0h want %0h", sram_addr, da); end
      n_checks++; if (sram_we !== 1'b0) begin n_fail++; $display("FAIL stall_disp_we: got %b want 0", sram_we); end
      n_checks++; if (host_ready !== 1'b0) begin n_fail++; $display("FAIL stall_host_ready: got %b want 0", host_ready); end
    end
    @(negedge clk);
    disp_req = 1'b0;
    #3;
    n_checks++; if (sram_addr !== 4'h5) begin n_fail++; $display("FAIL stall_issue_addr: got %0h want 5", sram_addr); end
    @(negedge clk);
    #3;
`ifdef VRAM_ARB_STATS_EN
    exp_st = 3;
`else
    exp_st = 0;
`endif
    n_checks++; if (host_rvalid !== 1'b1) begin n_fail++; $display("FAIL stall_rvalid: got %b want 1", host_rvalid); end
    n_checks++; if (host_rdata !== 8'h41) begin n_fail++; $display("FAIL stall_rdata: got %0h want 41", host_rdata); end
    n_checks++; if (host_stall_cnt !== 16'(exp_st)) begin n_fail++; $display("FAIL stall_cnt: got %0d want %0d", host_stall_cnt, exp_st); end
  endtask

  task automatic test_fill_only();
    int busy_cnt, first_done;
    apply_reset();
    @(negedge clk);
    fill_start = 1'b1; fill_value = 8'h20;
    busy_cnt = 0; first_done = -1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      fill_start = 1'b0;
      #3;
      if (fill_busy) busy_cnt++;
      if (fill_done && first_done < 0) first_done = k;
      if (k <= DEPTH) begin
        n_checks++;
        if (sram_we !== 1'b1 || sram_addr !== AW'(k - 1)) begin
          n_fail++; $display("FAIL fill_seq_write: we=%b addr=%0h want we=1 addr=%0h", sram_we, sram_addr, k - 1);
        end
      end
    end
    n_checks++; if (busy_cnt != DEPTH) begin n_fail++; $display("FAIL fill_busy_cycles: got %0d want %0d", busy_cnt, DEPTH); end
    n_checks++; if (first_done != DEPTH + 1) begin n_fail++; $display("FAIL fill_done_cycle: got %0d want %0d", first_done, DEPTH + 1); end
    for (int a = 0; a < DEPTH; a++) begin
      n_checks++;
      if (sram_mem[a] !== 8'h20) begin n_fail++; $display("FAIL fill_contents[%0d]: got %0h want 20", a, sram_mem[a]); end
    end
    for (int a = 0; a < DEPTH; a++) begin
      @(negedge clk);
      host_valid = 1'b1; host_we = 1'b0; host_addr = AW'(a);
    end
    @(negedge clk);
    drive_idle();
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_fill_host_rr();
    int busy_cnt;
    bit done_seen;
    logic [DW-1:0] fv;
    apply_reset();
    fv = DW'($urandom);
    @(negedge clk);
    fill_start = 1'b1; fill_value = fv;
    host_valid = 1'b1; host_we = 1'b1;
    host_addr = AW'($urandom); host_wdata = DW'($urandom);
    busy_cnt = 0; done_seen = 0;
    for (int k = 1; k <= 60 && !done_seen; k++) begin
      @(negedge clk);
      fill_start = 1'b0;
      host_addr = AW'($urandom); host_wdata = DW'($urandom);
      #3;
      if (fill_busy) busy_cnt++;
      if (fill_done) done_seen = 1;
      if (k <= 2 * DEPTH && (k % 2) == 0) begin
        n_checks++;
        if (sram_addr !== AW'(k / 2 - 1) || sram_wdata !== fv) begin
          n_fail++; $display("FAIL rr_fill_slot: addr=%0h data=%0h want addr=%0h data=%0h", sram_addr, sram_wdata, k / 2 - 1, fv);
        end
      end
    end
    n_checks++; if (!done_seen) begin n_fail++; $display("FAIL rr_fill_timeout: fill_done got 0 want 1 within 60 cycles"); end
    n_checks++; if (busy_cnt != 2 * DEPTH) begin n_fail++; $display("FAIL rr_busy_cycles: got %0d want %0d", busy_cnt, 2 * DEPTH); end
    @(negedge clk);
    drive_idle();
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_disp_during_fill();
    bit done_seen;
    logic [AW-1:0] da;
    @(negedge clk);
    fill_start = 1'b1; fill_value = DW'($urandom);
    done_seen = 0;
    for (int k = 1; k <= 40 && !done_seen; k++) begin
      @(negedge clk);
      fill_start = 1'b0;
      da = AW'($urandom);
      disp_req = ((k % 4) == 0); disp_addr = da;
      #3;
      if (fill_done) done_seen = 1;
      if (disp_req) begin
        n_checks++;
        if (sram_we !== 1'b0 || sram_addr !== da) begin
          n_fail++; $display("FAIL disp_fill_slot: we=%b addr=%0h want we=0 addr=%0h", sram_we, sram_addr, da);
        end
      end
    end
    n_checks++; if (!done_seen) begin n_fail++; $display("FAIL disp_fill_timeout: fill_done got 0 want 1 within 40 cycles"); end
    @(negedge clk);
    drive_idle();
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    fill_start = 1'b1; fill_value = DW'($urandom);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      fill_start = 1'b0;
    end
    @(negedge clk);
    host_valid = 1'b1; host_we = 1'b0; host_addr = 4'h3;
    @(negedge clk);
    host_valid = 1'b0;
    rst_n = 1'b0;
    #3;
    n_checks++; if (host_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_host_ready: got %b want 1", host_ready); end
    n_checks++; if (fill_busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_fill_busy: got %b want 0", fill_busy); end
    n_checks++; if (host_rvalid !== 1'b0) begin n_fail++; $display("FAIL rstmid_rvalid: got %b want 0", host_rvalid); end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      #3;
      n_checks++;
      if (host_rvalid !== 1'b0 || fill_busy !== 1'b0) begin
        n_fail++; $display("FAIL rstmid_after: rvalid=%b busy=%b want 0 0", host_rvalid, fill_busy);
      end
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 600; k++) begin
      @(negedge clk);
      disp_req   = ($urandom_range(0, 4) == 0);
      disp_addr  = AW'($urandom);
      host_valid = $urandom_range(0, 1) == 1;
      host_we    = $urandom_range(0, 1) == 1;
      host_addr  = AW'($urandom);
      host_wdata = DW'($urandom);
      fill_start = ($urandom_range(0, 49) == 0);
      fill_value = DW'($urandom);
    end
    @(negedge clk);
    drive_idle();
    for (int k = 0; k < 40; k++) @(negedge clk);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    mon_en   = 1'b0;
    sram_rdata = '0;
    for (int a = 0; a < DEPTH; a++) begin
      sram_mem[a] = '0;
      m_mem[a]    = 0;
    end
    test_reset();
    test_write_read();
    test_disp_stall();
    test_fill_only();
    test_fill_host_rr();
    test_disp_during_fill();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
